// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and sizes for the instruction-fetch stage.
package ifetch_pkg;
  localparam int FETCH_N = 32;
  localparam int FETCH_R = 6;
  localparam int FETCH_DEPTH = 2;
  typedef struct packed {
    logic [FETCH_R-1:0] pc;
    logic [FETCH_N-1:0] instr;
  } fetch_entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;
endpackage

// File: rtl/ifetch_skid_buf.sv
// ifetch_skid_buf: two-entry FIFO of fetch entries; head is held in a register
// so downstream outputs never see the imem data combinationally.
module ifetch_skid_buf
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_din,
  output logic         o_full,
  output logic         o_empty,
  output fetch_entry_t o_head
);
  buf_state_t   r_state, w_state_nxt;
  fetch_entry_t r_head, r_tail;
  logic         w_pop, w_push;
  assign w_pop  = i_pop & (r_state != EMPTY);
  assign w_push = i_push & ((r_state != FULL) | w_pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    if (i_flush)              w_state_nxt = EMPTY;
    else if (w_push & ~w_pop) w_state_nxt = (r_state == EMPTY) ? ONE : FULL;
    else if (w_pop & ~w_push) w_state_nxt = (r_state == FULL) ? ONE : EMPTY;
  end
  always_comb begin
    o_full  = (r_state == FULL);
    o_empty = (r_state == EMPTY);
    o_head  = r_head;
  end
  // Head refills from the tail when FULL, otherwise straight from the input.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (!i_flush) begin
      if (w_pop && r_state == FULL)
        r_head <= r_tail;
      else if (w_push && (r_state == EMPTY || (w_pop && r_state == ONE)))
        r_head <= i_din;
      if (w_push && ((r_state == ONE && !w_pop) || (r_state == FULL && w_pop)))
        r_tail <= i_din;
    end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: owns the PC, drives the imem address and hands {pc, instr}
// to decode through a two-entry skid buffer; redirects flush the buffer.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int N = FETCH_N,
  parameter int R = FETCH_R,
  parameter logic [R-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fetch_en,
  input  logic         redirect_valid,
  input  logic [R-1:0] redirect_addr,
  output logic [R-1:0] imem_addr,
  input  logic [N-1:0] imem_readdata,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_instr,
  output logic [R-1:0] out_pc
);
  logic [R-1:0] r_pc;
  logic         w_full, w_empty, w_pop, w_push;
  fetch_entry_t w_din, w_head;
  assign w_pop  = ~w_empty & out_ready;
  assign w_push = fetch_en & ~redirect_valid & (~w_full | w_pop);
  assign w_din  = '{pc: r_pc, instr: imem_readdata};
  // Redirect wins over push; PC wraps naturally at 2**R.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)              r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= redirect_addr;
    else if (w_push)         r_pc <= r_pc + 1'b1;
  ifetch_skid_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_din   (w_din),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );
  assign imem_addr = r_pc;
  assign out_valid = ~w_empty;
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed checks of ifetch_unit against hand-computed values.
module tb_ifetch_unit;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        fetch_en = 0;
  logic        redirect_valid = 0;
  logic [5:0]  redirect_addr = '0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_readdata;
  logic        out_valid;
  logic        out_ready = 1;
  logic [31:0] out_instr;
  logic [5:0]  out_pc;
  int          n_tests = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  assign imem_readdata = 32'hA000_0000 + {26'd0, imem_addr};
  ifetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_addr      (imem_addr),
    .imem_readdata  (imem_readdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic chk_out(input string tag, input logic [5:0] pc);
    chk({tag, " valid"}, 64'(out_valid), 64'd1);
    chk({tag, " pc"}, 64'(out_pc), 64'(pc));
    chk({tag, " instr"}, 64'(out_instr), 64'(32'hA000_0000 + {26'd0, pc}));
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst valid", 64'(out_valid), 64'd0);
    chk("rst instr", 64'(out_instr), 64'd0);
    chk("rst out_pc", 64'(out_pc), 64'd0);
    chk("rst addr", 64'(imem_addr), 64'd0);
    // 1: streaming, no bubbles
    rst_n = 1;
    fetch_en = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_out("stream", 6'(k));
    end
    // 2: backpressure fills the buffer and freezes the PC
    do_reset();
    step();
    chk_out("bp first", 6'd0);
    out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_out("bp hold", 6'd0);
      chk("bp addr", 64'(imem_addr), 64'd2);
    end
    out_ready = 1;
    for (int k = 1; k < 4; k++) begin
      step();
      chk_out("bp drain", 6'(k));
    end
    // 3: redirect while full drops the head
    redirect_valid = 1;
    redirect_addr = 6'd40;
    step();
    redirect_valid = 0;
    chk("redir valid", 64'(out_valid), 64'd0);
    chk("redir addr", 64'(imem_addr), 64'd40);
    step();
    chk_out("redir first", 6'd40);
    // 4: wrap-around
    redirect_valid = 1;
    redirect_addr = 6'd63;
    step();
    redirect_valid = 0;
    step();
    chk_out("wrap 63", 6'd63);
    step();
    chk_out("wrap 0", 6'd0);
    step();
    chk_out("wrap 1", 6'd1);
    // 5: fetch_en=0 drains without advancing PC
    out_ready = 0;
    step();
    chk_out("fill hold", 6'd1);
    chk("fill addr", 64'(imem_addr), 64'd3);
    fetch_en = 0;
    out_ready = 1;
    step();
    chk_out("drain 2", 6'd2);
    step();
    chk("drain empty", 64'(out_valid), 64'd0);
    chk("drain addr", 64'(imem_addr), 64'd3);
    step();
    chk("idle valid", 64'(out_valid), 64'd0);
    chk("idle addr", 64'(imem_addr), 64'd3);
    fetch_en = 1;
    step();
    chk_out("resume", 6'd3);
    // 6: asynchronous reset between edges
    step();
    #2 rst_n = 0;
    #1;
    chk("async valid", 64'(out_valid), 64'd0);
    chk("async addr", 64'(imem_addr), 64'd0);
    chk("async out_pc", 64'(out_pc), 64'd0);
    @(negedge clk);
    rst_n = 1;
    step();
    chk_out("post rst 0", 6'd0);
    step();
    chk_out("post rst 1", 6'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
